keypad_scan_source: RTL and testbench
=====================================

Name: keypad_scan_source

Overview:
- Scans a 4x4 matrix keypad: drives the rows active-low, samples the columns, and debounces the result over whole scans.
- Presents a 6-bit key status word, key_out, that feeds the in_port of the 6-bit edge-capture input PIO on the Nios II Avalon bus.
- Bit 4 of key_out is a one-cycle press pulse, so the PIO's edge capture raises an IRQ on each new key press.

Parameters:
- SCAN_DIV, 50000: clk cycles per row step (1 ms at 50 MHz). Legal range 3..2^20.
- DEBOUNCE_SCANS, 4: number of consecutive identical full-scan results required before the debounced state changes. Legal range 1..15.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- col_n  input  4  keypad columns, active-low, asynchronous, externally pulled up.
- row_n  output  4  keypad row drive, active-low one-hot.
- key_out  output  6  key status word, bit fields as follows:
  - [5] key_down, level.
  - [4] press_pulse, one cycle wide.
  - [3:0] key code = row*4 + col of the last accepted press.

Behaviour:
- Reset values: row_n=4'b1110; key_out=6'b0; div counter=0; row index=0; candidate=NONE; prev candidate=NONE; stable count=0. Reset mid-scan aborts the scan. Accepted state is lost.
- col_n passes through a 2-flop synchronizer (reset value 4'b1111). Synchronized value is called cols.
- Row step:
  - div counts 0..SCAN_DIV-1.
  - On div==SCAN_DIV-1: sample cols for the current row, advance the row index (wraps 3->0), and rotate row_n left (1110->1101->1011->0111->1110).
  - Row drive is otherwise constant. Settle time before sampling is SCAN_DIV-1 cycles.
- Per-scan accumulation:
  - Over rows 0..3, count active (low) cols bits and remember the last row/col seen.
  - Full scan = 4*SCAN_DIV cycles. At the end of the row-3 sample, the scan result is one of:
    - NONE: 0 bits active.
    - KEY(code): exactly 1 bit active.
    - MULTI: 2 or more bits active.
  - The accumulator clears for the next scan in the same cycle.
- Debounce, evaluated in the cycle after the row-3 sample (the "eval cycle"):
  - If result == prev candidate: stable = min(stable+1, 15). Otherwise stable = 1.
  - prev candidate <= result.
  - Accept when the updated stable == DEBOUNCE_SCANS. Acceptance fires only on that exact count, not repeatedly.
- Accepted-state transitions:
  - KEY(c) with key_down=0: key_down<=1, code<=c, press_pulse=1 for exactly one cycle (the cycle after the eval cycle).
  - NONE with key_down=1: key_down<=0. Code is held. No pulse.
  - MULTI: no change.
  - KEY(c') with key_down=1: no change. A new press requires an accepted release first.
  - NONE with key_down=0: no change.
- key_out is fully registered. press_pulse is 0 in every cycle except the one above.
- Bounce within a scan can only change that scan's result. It restarts the stable count and never produces a pulse.
- Latency:
  - Measured from the first full scan that sees a stable key (DEBOUNCE_SCANS>=1).
  - The pulse appears (DEBOUNCE_SCANS-1)*4*SCAN_DIV + 2 cycles after that scan's row-3 sample.
  - The synchronizer adds 2 cycles on the input side.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2, full scan = 16 cycles):
- Reset, no key: row_n sequence 1110,1101,1011,0111 repeats with a 4-cycle step. key_out stays 0x00 for 200 cycles. Assert reset mid-scan: row_n=1110 and key_out=0 on the next cycle.
- Press row 2/col 1 (model drives col_n[1] low while row_n[2]=0), held steady: after 2 full scans key_out goes 0x39 for one cycle (down, pulse, code 9), then holds 0x29.
- Release after that press: after 2 NONE scans key_out=0x09. No pulse. A later press of row0/col0 gives 0x30 pulse, then 0x20.
- Bounce: toggle col_n every 3 cycles for 5 scans, then hold key 5: no pulse during bouncing. Exactly one pulse (0x35) 2 scans after bouncing stops.
- Two keys (row1/col0 and row3/col3) held: MULTI result, key_out unchanged from 0x00, no pulse. Drop to row3/col3 only: pulse with code 15 (0x3F), then 0x2F.
- Key change without release (hold 9, then switch to 6): key_out stays 0x29 with no pulse. After release and a press of 6: 0x36 pulse.

Source files
------------

// File: rtl/keypad_scan_source.sv
// 4x4 matrix keypad scanner with whole-scan debounce. Produces a 6-bit status word
// {key_down, press_pulse, code} for a Nios II edge-capture PIO.
module keypad_scan_source #(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [5:0] key_out
);

    localparam int                DIV_W      = 20;
    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]        DEB_TARGET = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_KEY   = 2'd1,
        RES_MULTI = 2'd2
    } res_kind_e;

    typedef struct packed {
        res_kind_e  kind;
        logic [3:0] code;
    } scan_res_t;

    localparam scan_res_t RES_IDLE = '{kind: RES_NONE, code: 4'd0};

    logic [3:0]       colMeta_q;
    logic [3:0]       cols_q;
    logic [DIV_W-1:0] div_q,      div_d;
    logic [1:0]       rowIdx_q,   rowIdx_d;
    logic [3:0]       rowN_q,     rowN_d;
    logic [1:0]       accCount_q, accCount_d;
    logic [3:0]       accCode_q,  accCode_d;
    scan_res_t        result_q,   result_d;
    logic             eval_q,     eval_d;
    scan_res_t        prevRes_q,  prevRes_d;
    logic [3:0]       stable_q,   stable_d;
    logic             keyDown_q,  keyDown_d;
    logic [3:0]       keyCode_q,  keyCode_d;
    logic             pulse_q,    pulse_d;

    logic       rowStep;
    logic [2:0] rowPop;
    logic [1:0] colLast;
    logic [2:0] scanTotal;
    logic [3:0] codeNow;
    logic       resMatch;
    logic [3:0] stableNew;
    logic       accept;

    // Active-column count and highest active column index for the row being sampled.
    always_comb begin
        rowPop  = 3'd0;
        colLast = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!cols_q[i]) begin
                rowPop  = rowPop + 3'd1;
                colLast = 2'(i);
            end
        end
    end

    assign rowStep   = (div_q == DIV_LAST);
    assign scanTotal = {1'b0, accCount_q} + rowPop;
    assign codeNow   = (rowPop != 3'd0) ? {rowIdx_q, colLast} : accCode_q;

    // Row stepping and per-scan accumulation; the count saturates at 2 since only 0/1/many matter.
    always_comb begin
        div_d      = rowStep ? '0 : div_q + DIV_W'(1);
        rowIdx_d   = rowStep ? rowIdx_q + 2'd1 : rowIdx_q;
        rowN_d     = rowStep ? {rowN_q[2:0], rowN_q[3]} : rowN_q;
        accCount_d = accCount_q;
        accCode_d  = accCode_q;
        result_d   = result_q;
        eval_d     = 1'b0;
        if (rowStep) begin
            if (rowIdx_q == 2'd3) begin
                eval_d     = 1'b1;
                accCount_d = 2'd0;
                accCode_d  = 4'd0;
                if (scanTotal == 3'd0) begin
                    result_d = RES_IDLE;
                end else if (scanTotal == 3'd1) begin
                    result_d.kind = RES_KEY;
                    result_d.code = codeNow;
                end else begin
                    result_d.kind = RES_MULTI;
                    result_d.code = 4'd0;
                end
            end else begin
                accCount_d = (scanTotal >= 3'd2) ? 2'd2 : scanTotal[1:0];
                accCode_d  = codeNow;
            end
        end
    end

    // Debounce fires once, on the exact scan that reaches the target count.
    always_comb begin
        resMatch  = (result_q == prevRes_q);
        stableNew = !resMatch ? 4'd1 :
                    (stable_q == 4'd15) ? 4'd15 : stable_q + 4'd1;
        accept    = eval_q && (stableNew == DEB_TARGET);
        prevRes_d = eval_q ? result_q : prevRes_q;
        stable_d  = eval_q ? stableNew : stable_q;
        keyDown_d = keyDown_q;
        keyCode_d = keyCode_q;
        pulse_d   = 1'b0;
        if (accept) begin
            if (result_q.kind == RES_KEY && !keyDown_q) begin
                keyDown_d = 1'b1;
                keyCode_d = result_q.code;
                pulse_d   = 1'b1;
            end else if (result_q.kind == RES_NONE && keyDown_q) begin
                keyDown_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            colMeta_q  <= 4'hF;
            cols_q     <= 4'hF;
            div_q      <= '0;
            rowIdx_q   <= 2'd0;
            rowN_q     <= 4'b1110;
            accCount_q <= 2'd0;
            accCode_q  <= 4'd0;
            result_q   <= RES_IDLE;
            eval_q     <= 1'b0;
            prevRes_q  <= RES_IDLE;
            stable_q   <= 4'd0;
            keyDown_q  <= 1'b0;
            keyCode_q  <= 4'd0;
            pulse_q    <= 1'b0;
        end else begin
            colMeta_q  <= col_n;
            cols_q     <= colMeta_q;
            div_q      <= div_d;
            rowIdx_q   <= rowIdx_d;
            rowN_q     <= rowN_d;
            accCount_q <= accCount_d;
            accCode_q  <= accCode_d;
            result_q   <= result_d;
            eval_q     <= eval_d;
            prevRes_q  <= prevRes_d;
            stable_q   <= stable_d;
            keyDown_q  <= keyDown_d;
            keyCode_q  <= keyCode_d;
            pulse_q    <= pulse_d;
        end
    end

    assign row_n   = rowN_q;
    assign key_out = {keyDown_q, pulse_q, keyCode_q};

endmodule

// File: tb/tb_keypad_scan_source.sv
// Bench for keypad_scan_source: keypad matrix model, scripted scenario table,
// bounce/reset sequences and random presses compared against a scan-level reference.
module tb_keypad_scan_source;

    localparam int SD  = 4;
    localparam int DEB = 2;
    localparam int M_NONE  = -1;
    localparam int M_MULTI = -2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [5:0] key_out;

    logic [15:0] pressMask;
    logic [3:0]  bounceXor;
    logic [3:0]  padCols;

    int nChecks = 0;
    int nFails  = 0;
    int pulseCount = 0;
    logic [5:0] lastPulse = 6'h0;

    always #5 clk = ~clk;

    keypad_scan_source #(
        .SCAN_DIV      (SD),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .col_n  (col_n),
        .row_n  (row_n),
        .key_out(key_out)
    );

    // Keypad matrix: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        padCols = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row_n[r] && pressMask[r*4+c]) padCols[c] = 1'b0;
        col_n = padCols ^ bounceXor;
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: whole-scan key map, result history, trailing-run debounce.
    bit          mValid = 1'b0;
    int          mK;
    logic [3:0]  mColHist[$];
    logic [3:0]  mUsed;
    logic [15:0] mScan;
    int          mResHist[$];
    bit          mPending;
    int          mPendRes;
    logic        mDown;
    logic [3:0]  mCode;
    logic        mPulse;
    logic [3:0]  mRow;
    int          mRun;
    int          mIdx;

    function automatic int classify(input logic [15:0] bits);
        int n;
        n = $countones(bits);
        if (n == 0) return M_NONE;
        if (n > 1) return M_MULTI;
        for (int i = 0; i < 16; i++) if (bits[i]) return i;
        return M_MULTI;
    endfunction

    always @(negedge clk) begin
        if (mValid) begin
            mRow = 4'hF;
            mRow[(mK / SD) % 4] = 1'b0;
            checkOutput("row_n", 16'(row_n), 16'(mRow));
            checkOutput("key_out", 16'(key_out), 16'({mDown, mPulse, mCode}));
        end
        if (reset) begin
            mValid = 1'b1;
            mK = 0;
            mColHist.delete();
            mResHist.delete();
            mScan = 16'h0;
            mPending = 1'b0;
            mDown = 1'b0;
            mCode = 4'h0;
            mPulse = 1'b0;
        end else if (mValid) begin
            mColHist.push_back(col_n);
            if (mColHist.size() > 3) void'(mColHist.pop_front());
            mUsed = (mColHist.size() == 3) ? mColHist[0] : 4'hF;
            mPulse = 1'b0;
            if (mPending) begin
                mPending = 1'b0;
                mResHist.push_back(mPendRes);
                if (mResHist.size() > 16) void'(mResHist.pop_front());
                mRun = 0;
                mIdx = mResHist.size() - 1;
                while (mIdx >= 0 && mResHist[mIdx] == mPendRes) begin
                    mRun++;
                    mIdx--;
                end
                if (mRun > 15) mRun = 15;
                if (mRun == DEB) begin
                    if (mPendRes >= 0 && !mDown) begin
                        mDown = 1'b1;
                        mCode = 4'(mPendRes);
                        mPulse = 1'b1;
                    end else if (mPendRes == M_NONE && mDown) begin
                        mDown = 1'b0;
                    end
                end
            end
            if (mK % SD == SD - 1) begin
                for (int c = 0; c < 4; c++) mScan[((mK / SD) % 4) * 4 + c] = !mUsed[c];
                if ((mK / SD) % 4 == 3) begin
                    mPendRes = classify(mScan);
                    mPending = 1'b1;
                    mScan = 16'h0;
                end
            end
            mK++;
        end
    end

    always @(negedge clk) begin
        if (key_out[4] === 1'b1) begin
            pulseCount++;
            lastPulse = key_out;
        end
    end

    task automatic applyStimulus(input logic [15:0] mask, input logic [3:0] bx, input int cycles);
        @(posedge clk);
        #1;
        pressMask = mask;
        bounceXor = bx;
        repeat (cycles - 1) @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        string       name;
        logic [15:0] mask;
        int          hold;
        logic [5:0]  expKey;
        int          expPulses;
    } step_t;

    step_t      steps[12];
    logic [3:0] rowSeq[5];
    int         nz;
    int         sel;
    logic [15:0] rndMask;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        steps[0]  = '{"idle",        16'h0000, 64, 6'h00, 0};
        steps[1]  = '{"press9",      16'h0200, 64, 6'h29, 1};
        steps[2]  = '{"release9",    16'h0000, 64, 6'h09, 0};
        steps[3]  = '{"press0",      16'h0001, 64, 6'h20, 1};
        steps[4]  = '{"release0",    16'h0000, 64, 6'h00, 0};
        steps[5]  = '{"multi4_15",   16'h8010, 64, 6'h00, 0};
        steps[6]  = '{"drop_to15",   16'h8000, 64, 6'h2F, 1};
        steps[7]  = '{"release15",   16'h0000, 64, 6'h0F, 0};
        steps[8]  = '{"press9b",     16'h0200, 64, 6'h29, 1};
        steps[9]  = '{"switch6",     16'h0040, 64, 6'h29, 0};
        steps[10] = '{"release6",    16'h0000, 64, 6'h09, 0};
        steps[11] = '{"press6",      16'h0040, 64, 6'h26, 1};
        rowSeq[0] = 4'b1110;
        rowSeq[1] = 4'b1101;
        rowSeq[2] = 4'b1011;
        rowSeq[3] = 4'b0111;
        rowSeq[4] = 4'b1110;

        reset = 1'b1;
        pressMask = 16'h0;
        bounceXor = 4'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        nz = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (key_out !== 6'h00) nz++;
            if (i % 4 == 2 && i < 20) checkOutput("row_seq", 16'(row_n), 16'(rowSeq[i / 4]));
        end
        checkOutput("idle_nonzero_cycles", 16'(nz), 16'd0);

        for (int s = 0; s < 12; s++) begin
            pulseCount = 0;
            applyStimulus(steps[s].mask, 4'h0, steps[s].hold);
            checkOutput({steps[s].name, "_key_out"}, 16'(key_out), 16'(steps[s].expKey));
            checkOutput({steps[s].name, "_pulses"}, 16'(pulseCount), 16'(steps[s].expPulses));
        end

        applyStimulus(16'h0000, 4'h0, 64);
        checkOutput("pre_bounce_key_out", 16'(key_out), 16'h06);
        pulseCount = 0;
        @(posedge clk);
        #1;
        pressMask = 16'h0020;
        bounceXor = 4'hF;
        for (int i = 1; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (i % 3 == 0) bounceXor = ~bounceXor;
        end
        @(negedge clk);
        checkOutput("bounce_pulses", 16'(pulseCount), 16'd0);
        applyStimulus(16'h0020, 4'h0, 64);
        checkOutput("post_bounce_pulses", 16'(pulseCount), 16'd1);
        checkOutput("post_bounce_pulse_word", 16'(lastPulse), 16'h35);
        checkOutput("post_bounce_key_out", 16'(key_out), 16'h25);

        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midscan_reset_row_n", 16'(row_n), 16'hE);
        checkOutput("midscan_reset_key_out", 16'(key_out), 16'h00);
        @(posedge clk);
        #1 reset = 1'b0;
        applyStimulus(16'h0000, 4'h0, 64);

        for (int it = 0; it < 40; it++) begin
            sel = int'($urandom_range(0, 3));
            rndMask = 16'h0;
            if (sel == 1 || sel == 2) rndMask[$urandom_range(0, 15)] = 1'b1;
            if (sel == 3) begin
                rndMask[$urandom_range(0, 15)] = 1'b1;
                rndMask[$urandom_range(0, 15)] = 1'b1;
            end
            @(posedge clk);
            #1;
            pressMask = rndMask;
            repeat ($urandom_range(0, 12)) begin
                bounceXor = 4'($urandom_range(0, 15));
                @(posedge clk);
                #1;
            end
            bounceXor = 4'h0;
            repeat ($urandom_range(4, 70)) @(posedge clk);
            #1;
        end
        applyStimulus(16'h0000, 4'h0, 64);
        checkOutput("final_key_down", 16'(key_out[5]), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
